// File: rtl/ula_pkg.sv
// -----------------------------------------------------------------------------
// ula_pkg
// Shared definitions for the ULA issue/capture controller:
//   - 4-bit ALU operation codes driven on ALUControl
//   - request op-class encodings (req_optype)
//   - funct7 values that select alternate R-type / shift operations
//   - controller FSM state enum
//   - helper identifying shift codes (their B operand is masked to 5 bits)
// -----------------------------------------------------------------------------
package ula_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CODE_W = 4;

  // ALU operation codes
  localparam logic [CODE_W-1:0] ULA_ADD = 4'b0000;
  localparam logic [CODE_W-1:0] ULA_SUB = 4'b0001;
  localparam logic [CODE_W-1:0] ULA_AND = 4'b0010;
  localparam logic [CODE_W-1:0] ULA_OR  = 4'b0011;
  localparam logic [CODE_W-1:0] ULA_XOR = 4'b0100;
  localparam logic [CODE_W-1:0] ULA_SLL = 4'b0101;
  localparam logic [CODE_W-1:0] ULA_SRL = 4'b0110;
  localparam logic [CODE_W-1:0] ULA_MUL = 4'b0111;
  localparam logic [CODE_W-1:0] ULA_EQ  = 4'b1000;

  // Request operation classes
  localparam logic [1:0] OPT_R    = 2'b00;
  localparam logic [1:0] OPT_I    = 2'b01;
  localparam logic [1:0] OPT_BR   = 2'b10;
  localparam logic [1:0] OPT_ADDR = 2'b11;

  // funct7 selectors
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Shift operations only use the low 5 bits of B as the shift amount
  function automatic logic is_shift(input logic [CODE_W-1:0] code);
    return (code == ULA_SLL) || (code == ULA_SRL);
  endfunction

endpackage

// File: rtl/ula_decoder.sv
// -----------------------------------------------------------------------------
// ula_decoder
// Purely combinational decode of a RISC-V-style request into an ALU code.
// Ports:
//   i_optype  [1:0] : op class (R / I / branch / address-add)
//   i_funct3  [2:0] : instruction funct3
//   i_funct7  [6:0] : instruction funct7 (only consulted where it matters)
//   o_code    [3:0] : ALU operation code (ULA_ADD when illegal)
//   o_illegal       : request does not decode to a supported operation
// -----------------------------------------------------------------------------
module ula_decoder
  import ula_pkg::*;
(
  input  logic [1:0]        i_optype,
  input  logic [2:0]        i_funct3,
  input  logic [6:0]        i_funct7,
  output logic [CODE_W-1:0] o_code,
  output logic              o_illegal
);

  // Op-class / funct decode to ALU code and legality
  always_comb begin
    o_code    = ULA_ADD;
    o_illegal = 1'b0;
    case (i_optype)
      OPT_R: begin
        if (i_funct7 == F7_BASE) begin
          case (i_funct3)
            3'b000:  o_code = ULA_ADD;
            3'b001:  o_code = ULA_SLL;
            3'b100:  o_code = ULA_XOR;
            3'b101:  o_code = ULA_SRL;
            3'b110:  o_code = ULA_OR;
            3'b111:  o_code = ULA_AND;
            default: o_illegal = 1'b1;
          endcase
        end else if ((i_funct7 == F7_ALT) && (i_funct3 == 3'b000)) begin
          o_code = ULA_SUB;
        end else if ((i_funct7 == F7_MULDIV) && (i_funct3 == 3'b000)) begin
          o_code = ULA_MUL;
        end else begin
          o_illegal = 1'b1;
        end
      end
      OPT_I: begin
        case (i_funct3)
          3'b000: o_code = ULA_ADD;
          3'b100: o_code = ULA_XOR;
          3'b110: o_code = ULA_OR;
          3'b111: o_code = ULA_AND;
          // Immediate shifts: funct7 must be all zero (no srai support)
          3'b001: begin
            if (i_funct7 == F7_BASE) begin
              o_code = ULA_SLL;
            end else begin
              o_illegal = 1'b1;
            end
          end
          3'b101: begin
            if (i_funct7 == F7_BASE) begin
              o_code = ULA_SRL;
            end else begin
              o_illegal = 1'b1;
            end
          end
          default: o_illegal = 1'b1;
        endcase
      end
      OPT_BR: begin
        // beq/bne both compare via subtraction; the consumer reads Zero
        if ((i_funct3 == 3'b000) || (i_funct3 == 3'b001)) begin
          o_code = ULA_SUB;
        end else begin
          o_illegal = 1'b1;
        end
      end
      OPT_ADDR: o_code = ULA_ADD;
      default:  o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ula_controle.sv
// -----------------------------------------------------------------------------
// ula_controle
// Issue/capture controller in front of a combinational ULA instance.
// A request is accepted in IDLE, decoded and latched; legal requests spend
// exactly one EXEC cycle driving the ALU, then the result is held in RESP
// until the consumer accepts it. Illegal requests skip EXEC entirely.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   req_valid / req_ready     : request handshake (ready only in IDLE)
//   req_optype/funct3/funct7  : operation selection
//   req_a, req_b              : operands
//   ALUControl, A, B          : ALU drive (zero outside EXEC)
//   ALUResult, Zero           : ALU outputs, sampled only in EXEC
//   rsp_valid / rsp_ready     : response handshake
//   rsp_result/zero/illegal   : captured response
// -----------------------------------------------------------------------------
module ula_controle
  import ula_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_optype,
  input  logic [2:0]        req_funct3,
  input  logic [6:0]        req_funct7,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [CODE_W-1:0] ALUControl,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic              Zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_illegal
);

  state_t              r_state;
  state_t              w_next_state;
  logic [CODE_W-1:0]   w_code;
  logic                w_illegal;
  logic [DATA_W-1:0]   w_b_drive;
  logic [CODE_W-1:0]   r_alu_code;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [DATA_W-1:0]   r_result;
  logic                r_zero;
  logic                r_illegal;

  ula_decoder u_decoder (
    .i_optype  (req_optype),
    .i_funct3  (req_funct3),
    .i_funct7  (req_funct7),
    .o_code    (w_code),
    .o_illegal (w_illegal)
  );

  // Shift amount masking: shifts see only req_b[4:0]
  always_comb begin
    if (is_shift(w_code)) begin
      w_b_drive = {27'd0, req_b[4:0]};
    end else begin
      w_b_drive = req_b;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_next_state = w_illegal ? ST_RESP : ST_EXEC;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_EXEC: w_next_state = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RESP;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Datapath: ALU drive registers are non-zero only during EXEC; response
  // registers are loaded at acceptance / end of EXEC and held through RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_code <= ULA_ADD;
      r_alu_a    <= 32'd0;
      r_alu_b    <= 32'd0;
      r_result   <= 32'd0;
      r_zero     <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_result  <= 32'd0;
            r_zero    <= 1'b0;
            r_illegal <= w_illegal;
            if (w_illegal) begin
              r_alu_code <= ULA_ADD;
              r_alu_a    <= 32'd0;
              r_alu_b    <= 32'd0;
            end else begin
              r_alu_code <= w_code;
              r_alu_a    <= req_a;
              r_alu_b    <= w_b_drive;
            end
          end
        end
        ST_EXEC: begin
          r_result   <= ALUResult;
          r_zero     <= Zero;
          r_alu_code <= ULA_ADD;
          r_alu_a    <= 32'd0;
          r_alu_b    <= 32'd0;
        end
        ST_RESP: begin
          r_result <= r_result;
        end
        default: begin
          r_alu_code <= ULA_ADD;
          r_alu_a    <= 32'd0;
          r_alu_b    <= 32'd0;
          r_result   <= 32'd0;
          r_zero     <= 1'b0;
          r_illegal  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign rsp_valid   = (r_state == ST_RESP);
  assign ALUControl  = r_alu_code;
  assign A           = r_alu_a;
  assign B           = r_alu_b;
  assign rsp_result  = r_result;
  assign rsp_zero    = r_zero;
  assign rsp_illegal = r_illegal;

endmodule

// File: tb/tb_ula_controle.sv
// -----------------------------------------------------------------------------
// tb_ula_controle
// Self-checking bench: a behavioural ULA drives ALUResult/Zero, and a
// reference model computes the expected response straight from the
// operation semantics. Directed cases plus randomized requests.
// -----------------------------------------------------------------------------
module tb_ula_controle;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_optype;
  logic [2:0]  req_funct3;
  logic [6:0]  req_funct7;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  ALUControl;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_illegal;

  int  n_cmp = 0;
  int  n_err = 0;
  time prev_acc = 0;

  typedef enum {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_MUL, OP_BAD} op_e;

  always #5 clk = ~clk;

  ula_controle dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_optype  (req_optype),
    .req_funct3  (req_funct3),
    .req_funct7  (req_funct7),
    .req_a       (req_a),
    .req_b       (req_b),
    .ALUControl  (ALUControl),
    .A           (A),
    .B           (B),
    .ALUResult   (ALUResult),
    .Zero        (Zero),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero),
    .rsp_illegal (rsp_illegal)
  );

  // Behavioural combinational ULA
  always_comb begin
    ALUResult = 32'd0;
    case (ALUControl)
      4'd0: ALUResult = A + B;
      4'd1: ALUResult = A - B;
      4'd2: ALUResult = A & B;
      4'd3: ALUResult = A | B;
      4'd4: ALUResult = A ^ B;
      4'd5: ALUResult = A << B[4:0];
      4'd6: ALUResult = A >> B[4:0];
      4'd7: ALUResult = A * B;
      4'd8: ALUResult = (A == B) ? 32'd1 : 32'd0;
      default: ALUResult = 32'd0;
    endcase
  end
  assign Zero = (ALUResult == 32'd0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: pick the operation from the instruction rules, then evaluate it
  function automatic void ref_model(input logic [1:0] ot, input logic [2:0] f3, input logic [6:0] f7,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic ill, output logic [3:0] code,
                                    output logic [31:0] bdrv, output logic [31:0] res);
    op_e op;
    op = OP_BAD;
    if (ot == 2'd3) begin
      op = OP_ADD;
    end else if (ot == 2'd2) begin
      if (f3 == 3'd0 || f3 == 3'd1) op = OP_SUB;
    end else if (ot == 2'd1) begin
      if      (f3 == 3'd0) op = OP_ADD;
      else if (f3 == 3'd4) op = OP_XOR;
      else if (f3 == 3'd6) op = OP_OR;
      else if (f3 == 3'd7) op = OP_AND;
      else if (f3 == 3'd1 && f7 == 7'd0) op = OP_SLL;
      else if (f3 == 3'd5 && f7 == 7'd0) op = OP_SRL;
    end else begin
      if (f7 == 7'd0) begin
        if      (f3 == 3'd0) op = OP_ADD;
        else if (f3 == 3'd1) op = OP_SLL;
        else if (f3 == 3'd4) op = OP_XOR;
        else if (f3 == 3'd5) op = OP_SRL;
        else if (f3 == 3'd6) op = OP_OR;
        else if (f3 == 3'd7) op = OP_AND;
      end else if (f7 == 7'h20 && f3 == 3'd0) begin
        op = OP_SUB;
      end else if (f7 == 7'h01 && f3 == 3'd0) begin
        op = OP_MUL;
      end
    end
    ill  = (op == OP_BAD);
    bdrv = (op == OP_SLL || op == OP_SRL) ? (b % 32'd32) : b;
    code = 4'd0;
    res  = 32'd0;
    case (op)
      OP_ADD: begin code = 4'd0; res = a + b; end
      OP_SUB: begin code = 4'd1; res = a - b; end
      OP_AND: begin code = 4'd2; res = a & b; end
      OP_OR:  begin code = 4'd3; res = a | b; end
      OP_XOR: begin code = 4'd4; res = a ^ b; end
      OP_SLL: begin code = 4'd5; res = a * (32'd1 << (b % 32'd32)); end
      OP_SRL: begin code = 4'd6; res = a / (32'd1 << (b % 32'd32)); end
      OP_MUL: begin code = 4'd7; res = a * b; end
      default: begin code = 4'd0; res = 32'd0; bdrv = 32'd0; end
    endcase
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"},   {31'd0, req_ready},   32'd1);
    chk({tag, "_rsp_valid"},   {31'd0, rsp_valid},   32'd0);
    chk({tag, "_rsp_result"},  rsp_result,           32'd0);
    chk({tag, "_rsp_zero"},    {31'd0, rsp_zero},    32'd0);
    chk({tag, "_rsp_illegal"}, {31'd0, rsp_illegal}, 32'd0);
    chk({tag, "_alu_ctrl"},    {28'd0, ALUControl},  32'd0);
    chk({tag, "_alu_a"},       A,                    32'd0);
    chk({tag, "_alu_b"},       B,                    32'd0);
  endtask

  // One full request/response transaction with optional backpressure
  task automatic run_op(input logic [1:0] ot, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit stray, input bit check_cad);
    logic        ill;
    logic [3:0]  code;
    logic [31:0] bd;
    logic [31:0] res;
    ref_model(ot, f3, f7, a, b, ill, code, bd, res);
    @(negedge clk);
    rsp_ready  = (hold == 0);
    req_optype = ot;
    req_funct3 = f3;
    req_funct7 = f7;
    req_a      = a;
    req_b      = b;
    req_valid  = 1'b1;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (check_cad) chk("cadence_cycles", 32'(($time - prev_acc) / 10), 32'd3);
    prev_acc = $time;
    if (!ill) begin
      chk("exec_alu_ctrl", {28'd0, ALUControl}, {28'd0, code});
      chk("exec_alu_a",    A, a);
      chk("exec_alu_b",    B, bd);
      chk("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("exec_req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    chk("rsp_valid",    {31'd0, rsp_valid},   32'd1);
    chk("rsp_result",   rsp_result,           res);
    chk("rsp_zero",     {31'd0, rsp_zero},    {31'd0, (!ill && res == 32'd0)});
    chk("rsp_illegal",  {31'd0, rsp_illegal}, {31'd0, ill});
    chk("resp_alu_ctrl", {28'd0, ALUControl}, 32'd0);
    chk("resp_alu_a",   A, 32'd0);
    chk("resp_alu_b",   B, 32'd0);
    for (int i = 0; i < hold; i++) begin
      if (stray) begin
        @(negedge clk);
        req_optype = 2'd3;
        req_a      = $urandom;
        req_valid  = 1'b1;
      end
      @(posedge clk);
      #1;
      chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      chk("hold_result",    rsp_result,         res);
      chk("hold_illegal",   {31'd0, rsp_illegal}, {31'd0, ill});
    end
    if (hold > 0) begin
      @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("drop_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("drop_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  // Accept a legal request, optionally advance to RESP, then reset
  task automatic reset_mid(input bit in_resp);
    @(negedge clk);
    rsp_ready  = 1'b0;
    req_optype = 2'd0;
    req_funct3 = 3'd0;
    req_funct7 = 7'd0;
    req_a      = 32'd5;
    req_b      = 32'd7;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("pre_reset_alu_a", A, 32'd5);
    if (in_resp) begin
      @(posedge clk);
      #1;
      chk("pre_reset_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("pre_reset_result",    rsp_result,          32'd12);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_reset_vals(in_resp ? "rst_in_resp" : "rst_in_exec");
    rsp_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_optype = 2'd0;
    req_funct3 = 3'd0;
    req_funct7 = 7'd0;
    req_a      = 32'd0;
    req_b      = 32'd0;
    rsp_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 1'b0;

    // Directed cases
    run_op(2'd0, 3'd0, 7'h00, 32'd5, 32'd7, 0, 1'b0, 1'b0);                 // add
    run_op(2'd0, 3'd0, 7'h20, 32'h1234, 32'h1234, 0, 1'b0, 1'b0);           // sub -> zero
    run_op(2'd2, 3'd0, 7'h00, 32'd3, 32'd4, 0, 1'b0, 1'b0);                 // beq not equal
    run_op(2'd1, 3'd1, 7'h00, 32'd1, 32'hFFFF_FFE4, 0, 1'b0, 1'b0);         // slli by 4
    run_op(2'd1, 3'd1, 7'h20, 32'd1, 32'd4, 0, 1'b0, 1'b0);                 // illegal slli
    run_op(2'd0, 3'd0, 7'h01, 32'h10000, 32'h10000, 5, 1'b1, 1'b0);         // mul + backpressure
    run_op(2'd0, 3'd5, 7'h00, 32'h8000_0000, 32'd31, 0, 1'b0, 1'b0);        // srl max shift
    run_op(2'd2, 3'd2, 7'h00, 32'd1, 32'd1, 2, 1'b1, 1'b0);                 // illegal branch

    // Back-to-back address-add with funct3 ignored
    run_op(2'd3, 3'd7, 7'h7F, 32'd100, 32'd23, 0, 1'b0, 1'b0);
    run_op(2'd3, 3'd7, 7'h7F, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, 1'b1);
    run_op(2'd3, 3'd7, 7'h7F, 32'h0F0F_0000, 32'h0000_F0F0, 0, 1'b0, 1'b1);

    // Reset during EXEC, then during RESP
    reset_mid(1'b0);
    reset_mid(1'b1);

    // Randomized requests
    for (int n = 0; n < 60; n++) begin
      logic [6:0] f7;
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      run_op(2'($urandom), 3'($urandom), f7, $urandom, $urandom,
             int'($urandom_range(0, 2)), 1'($urandom), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
